ram_sdp_clr: RTL

//   Parametrised simple-dual-port RAM (one write port, one read port) on a single clock.

---
 rtl/ram_sdp_clr.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr
//   Simple-dual-port RAM (one write port, one read port) on a single clock.
//   It has a clear sequencer that writes INIT_VAL to every word after reset or
//   on request. Other features:
//     - a selectable same-address read-during-write policy
//     - an optional output register
//     - a read-valid strobe
//     - out-of-range address detection on both ports
//
// Ports
//   clk_i        clock, all logic on posedge
//   rst_ni       asynchronous active-low reset
//   clr_req_i    1-cycle request to re-clear the array (honoured only in RUN)
//   clr_busy_o   high while the clear sequence runs; the ports are ignored then
//   we_i         write enable
//   waddr_i      write address
//   din_i        write data
//   re_i         read enable
//   raddr_i      read address
//   dout_o       read data; holds its value between reads
//   dout_vld_o   1-cycle strobe marking new dout_o
//   wr_drop_o    1-cycle pulse: write rejected (busy or waddr_i >= DEPTH)
//   rd_err_o     1-cycle pulse with dout_vld_o: raddr_i was >= DEPTH
module ram_sdp_clr #(
  parameter int               DATA_W   = 8,
  parameter int               ADDR_W   = 3,
  parameter int               DEPTH    = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int               RDW_MODE = 0,
  parameter int               OUT_REG  = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_vld_o,
  output logic              wr_drop_o,
  output logic              rd_err_o
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // Address bounds, widened by one bit so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              wr_drop_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              waddr_ok;
  logic              raddr_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;
  logic              rd_err_q;

  assign run      = (state_q == ST_RUN);
  assign waddr_ok = ({1'b0, waddr_i} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr_i} < DEPTH_W);
  assign wr_fire  = run && we_i && waddr_ok;
  assign rd_fire  = run && re_i;

  // The clear sequencer owns the write port for the whole CLEAR state.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr_i;
    mem_wdata = din_i;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = INIT_VAL;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read word selection.
  // - Out-of-range addresses read as zero.
  // - With RDW_MODE=1, a same-address write in the same cycle is forwarded.
  // - Otherwise the array read returns the contents from before this edge's write.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      if ((RDW_MODE == 1) && wr_fire && (waddr_i == raddr_i)) begin
        rd_word = din_i;
      end else begin
        rd_word = mem[raddr_i];
      end
    end
  end

  // Control FSM with the clear counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= we_i && (!run || !waddr_ok);
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q   <= ST_RUN;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          if (clr_req_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  // First read stage; data register only loads on an accepted read so dout holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_fire;
      rd_err_q <= rd_fire && !raddr_ok;
      if (rd_fire) begin
        rd_data_q <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] dout2_q;
      logic              vld2_q;
      logic              err2_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dout2_q <= '0;
          vld2_q  <= 1'b0;
          err2_q  <= 1'b0;
        end else begin
          vld2_q <= rd_vld_q;
          err2_q <= rd_err_q;
          if (rd_vld_q) begin
            dout2_q <= rd_data_q;
          end
        end
      end

      assign dout_o     = dout2_q;
      assign dout_vld_o = vld2_q;
      assign rd_err_o   = err2_q;
    end else begin : g_no_out_reg
      assign dout_o     = rd_data_q;
      assign dout_vld_o = rd_vld_q;
      assign rd_err_o   = rd_err_q;
    end
  endgenerate

  assign clr_busy_o = (state_q == ST_CLEAR);
  assign wr_drop_o  = wr_drop_q;

endmodule
